// File: rtl/fft_reorder_buf.sv
// Ping-pong bit-reversal reorder buffer: frames arrive in bit-reversed order
// and leave in natural order, with optional per-frame pass-through.
module fft_reorder_buf #(
    parameter int DW    = 16,
    parameter int LOG2N = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_r,
    input  logic [DW-1:0]    in_i,
    input  logic             in_last,
    input  logic             bypass,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_r,
    output logic [DW-1:0]    out_i,
    output logic [LOG2N-1:0] out_idx,
    output logic             out_last,
    output logic             frame_err
);
    localparam logic [LOG2N-1:0] CNT_LAST = {LOG2N{1'b1}};
    localparam logic [LOG2N-1:0] CNT_ZERO = {LOG2N{1'b0}};
    localparam int               DEPTH    = 2 * (2 ** LOG2N);

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        r = CNT_ZERO;
        for (int b = 0; b < LOG2N; b++) r[b] = v[LOG2N-1-b];
        return r;
    endfunction

    logic [2*DW-1:0]  mem_q [DEPTH];
    logic [1:0]       full_q, full_d;
    logic [1:0]       byp_q, byp_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0] wcnt_q, wcnt_d;
    logic [LOG2N-1:0] rcnt_q, rcnt_d;
    logic             err_q, err_d;

    logic             wr_en_s, rd_en_s, wr_byp_s;
    logic [LOG2N-1:0] wr_addr_s;
    logic [2*DW-1:0]  rd_data_s;

    // Handshakes, output mux and next-state for the bank pointers and flags.
    always_comb begin
        in_ready  = ~full_q[wr_bank_q];
        out_valid = full_q[rd_bank_q];
        wr_en_s   = in_valid & in_ready;
        rd_en_s   = out_valid & out_ready;
        // The bypass bit is taken live on the first sample, latched afterwards.
        wr_byp_s  = (wcnt_q == CNT_ZERO) ? bypass : byp_q[wr_bank_q];
        wr_addr_s = wr_byp_s ? wcnt_q : bitrev(wcnt_q);
        rd_data_s = mem_q[{rd_bank_q, rcnt_q}];
        out_r     = out_valid ? rd_data_s[2*DW-1:DW] : {DW{1'b0}};
        out_i     = out_valid ? rd_data_s[DW-1:0] : {DW{1'b0}};
        out_idx   = rcnt_q;
        out_last  = out_valid & (rcnt_q == CNT_LAST);
        frame_err = err_q;

        full_d    = full_q;
        byp_d     = byp_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        err_d     = err_q;

        if (wr_en_s) begin
            wcnt_d = wcnt_q + LOG2N'(1);
            if (wcnt_q == CNT_ZERO) begin
                byp_d[wr_bank_q] = bypass;
            end else begin
                byp_d = byp_q;
            end
            if (in_last != (wcnt_q == CNT_LAST)) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
            if (wcnt_q == CNT_LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_bank_d = wr_bank_q;
            end
        end else begin
            wcnt_d = wcnt_q;
        end

        // Read completion targets the other bank, so it never collides with the write.
        if (rd_en_s) begin
            rcnt_d = rcnt_q + LOG2N'(1);
            if (rcnt_q == CNT_LAST) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                rd_bank_d = rd_bank_q;
            end
        end else begin
            rcnt_d = rcnt_q;
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q    <= 2'b00;
            byp_q     <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wcnt_q    <= CNT_ZERO;
            rcnt_q    <= CNT_ZERO;
            err_q     <= 1'b0;
        end else begin
            full_q    <= full_d;
            byp_q     <= byp_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            err_q     <= err_d;
        end
    end

    // Sample storage for both banks; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s && rst) begin
            mem_q[{wr_bank_q, wr_addr_s}] <= {in_r, in_i};
        end
    end
endmodule

// File: tb/tb_fft_reorder_buf.sv
// Self-checking bench for fft_reorder_buf: directed scenarios plus random
// traffic, compared against a frame-level queue model.
module tb_fft_reorder_buf;
    localparam int DW    = 16;
    localparam int LOG2N = 5;
    localparam int N     = 32;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, in_last, bypass;
    logic             out_valid, out_ready, out_last, frame_err;
    logic [DW-1:0]    in_r, in_i, out_r, out_i;
    logic [LOG2N-1:0] out_idx;

    fft_reorder_buf #(.DW(DW), .LOG2N(LOG2N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
        .in_last(in_last), .bypass(bypass),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
        .out_idx(out_idx), .out_last(out_last), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_acc = 0;
    bit chk_en = 1'b0;

    // Reference model: completed frames are expanded into natural order.
    logic [DW-1:0] exp_r[$];
    logic [DW-1:0] exp_i[$];
    logic [DW-1:0] cur_r[N];
    logic [DW-1:0] cur_i[N];
    bit            cur_byp;
    int            held, m_wcnt, m_rcnt;
    bit            m_err;

    function automatic int rev(input int n);
        int r = 0;
        int v = n;
        for (int b = 0; b < LOG2N; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        exp_r.delete();
        exp_i.delete();
        held = 0; m_wcnt = 0; m_rcnt = 0; m_err = 1'b0; cur_byp = 1'b0;
    endtask

    task automatic cyc(input logic v, input logic l, input logic b, input logic ordy,
                       input logic [DW-1:0] r, input logic [DW-1:0] im, input logic rs);
        bit acc, xfer;
        rst = rs; in_valid = v; in_last = l; bypass = b; out_ready = ordy;
        in_r = r; in_i = im;
        #1;
        if (chk_en) begin
            chk("in_ready", in_ready, held < 2);
            chk("out_valid", out_valid, held > 0);
            chk("frame_err", frame_err, m_err);
            chk("out_idx", out_idx, m_rcnt);
            if (held > 0) begin
                chk("out_r", out_r, exp_r[0]);
                chk("out_i", out_i, exp_i[0]);
                chk("out_last", out_last, m_rcnt == N - 1);
            end else begin
                chk("out_r_idle", out_r, 0);
                chk("out_i_idle", out_i, 0);
                chk("out_last_idle", out_last, 0);
            end
        end
        acc  = rs && v && (held < 2);
        xfer = rs && ordy && (held > 0);
        @(posedge clk);
        #1;
        if (!rs) begin
            model_reset();
        end else begin
            if (xfer) begin
                void'(exp_r.pop_front());
                void'(exp_i.pop_front());
                m_rcnt++;
                if (m_rcnt == N) begin
                    m_rcnt = 0;
                    held--;
                end
            end
            if (acc) begin
                n_acc++;
                if (m_wcnt == 0) cur_byp = b;
                if (l != (m_wcnt == N - 1)) m_err = 1'b1;
                cur_r[m_wcnt] = r;
                cur_i[m_wcnt] = im;
                m_wcnt++;
                if (m_wcnt == N) begin
                    // Natural index n came from arrival slot rev(n) unless bypassed.
                    for (int n = 0; n < N; n++) begin
                        exp_r.push_back(cur_r[cur_byp ? n : rev(n)]);
                        exp_i.push_back(cur_i[cur_byp ? n : rev(n)]);
                    end
                    held++;
                    m_wcnt = 0;
                end
            end
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int c = 0; c < n; c++) cyc(1'b0, 1'b0, 1'b0, ordy, '0, '0, 1'b1);
    endtask

    // byp_mode: 0 = reorder, 1 = bypass, 2 = bypass with mid-frame toggle to 0.
    task automatic frame(input int bad_k, input int byp_mode, input bit rnd, input logic ordy);
        int start = n_acc;
        for (int c = 0; c < 200 && (n_acc - start) < N; c++) begin
            logic l, b;
            logic [DW-1:0] r, im;
            l  = (bad_k >= 0) ? (m_wcnt == bad_k) : (m_wcnt == N - 1);
            b  = (byp_mode == 1) || (byp_mode == 2 && m_wcnt < 10);
            r  = rnd ? DW'($urandom) : DW'(m_wcnt);
            im = rnd ? DW'($urandom) : DW'(-m_wcnt);
            cyc(1'b1, l, b, ordy, r, im, 1'b1);
        end
    endtask

    initial begin
        int s;
        model_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        chk_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

        frame(-1, 0, 1'b0, 1'b1);
        idle(40, 1'b1);
        frame(-1, 2, 1'b0, 1'b1);
        idle(40, 1'b1);

        // Backpressure: 70 offered with the consumer stalled, then release.
        for (int k = 0; k < 70; k++)
            cyc(1'b1, m_wcnt == N - 1, 1'b0, 1'b0, DW'(k), DW'(-k), 1'b1);
        idle(80, 1'b1);

        for (int f = 0; f < 4; f++) frame(-1, int'($urandom_range(0, 1)), 1'b1, 1'b1);
        idle(40, 1'b1);

        frame(20, 0, 1'b1, 1'b1);
        frame(-1, 0, 1'b1, 1'b1);
        idle(40, 1'b1);

        // Reset after 40 accepts, with one complete and one partial frame held.
        s = n_acc;
        for (int c = 0; c < 100 && (n_acc - s) < 40; c++)
            cyc(1'b1, m_wcnt == N - 1, 1'b0, 1'b0, DW'($urandom), DW'($urandom), 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
        idle(1, 1'b1);
        frame(-1, 0, 1'b1, 1'b1);
        idle(40, 1'b1);

        for (int c = 0; c < 600; c++)
            cyc($urandom_range(0, 3) != 0, m_wcnt == N - 1, 1'($urandom),
                $urandom_range(0, 2) != 0, DW'($urandom), DW'($urandom), 1'b1);
        idle(80, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fft_reorder_buf.md
Name: fft_reorder_buf

Overview:
- Parametrised bit-reversal reorder buffer between the radix-2 FFT pipeline output and downstream consumers.
- Accepts one complex sample per cycle in bit-reversed frame order and emits each frame in natural order.
- Ping-pong double buffering lets one frame be written while the previous frame drains.
- Valid/ready handshakes on both sides, a per-frame bypass mode, and a sticky frame-length error flag.

Parameters:
- DW, 16, width of each real/imag component (signed two's complement).
- LOG2N, 5, log2 of frame length; N = 2**LOG2N points per frame (legal range 2..10).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  input  1  input sample present.
- in_ready  output  1  buffer can accept a sample this cycle.
- in_r  input  DW  input real part.
- in_i  input  DW  input imaginary part.
- in_last  input  1  marks the final sample of a frame, checked only.
- bypass  input  1  1 = store the frame in arrival order, no reordering.
- out_valid  output  1  output sample present.
- out_ready  input  1  consumer accepts the sample.
- out_r  output  DW  output real part.
- out_i  output  DW  output imaginary part.
- out_idx  output  LOG2N  natural-order index of the current output sample.
- out_last  output  1  high with out_idx = N-1 while out_valid is high.
- frame_err  output  1  sticky error flag.

Behaviour:
- Storage: two banks, each N x 2DW. Banks are not reset.
- Per-bank state: full flag and latched bypass bit.
- Pointers: wr_bank, rd_bank (1 bit each); wcnt, rcnt (LOG2N bits each).
- Reset (rst=0 at a clk edge): all state is cleared.
  - Full flags = 0; wr_bank = rd_bank = 0; wcnt = rcnt = 0; frame_err = 0.
  - Outputs during and after reset until the first frame completes: in_ready = 1, out_valid = 0, out_r = out_i = 0, out_idx = 0, out_last = 0.
  - A reset mid-frame discards both partial and complete frames.
- Write accept: accepted when in_valid && in_ready, with in_ready = !full[wr_bank].
  - Write address = bypass_lat ? wcnt : bitrev(wcnt), where bitrev reverses all LOG2N bits.
  - When wcnt == 0, the bypass input is latched into the bank's bypass bit and is used for the whole frame. Changes to bypass mid-frame are ignored.
  - wcnt increments on each accept.
  - On the accept with wcnt == N-1: wcnt wraps to 0, full[wr_bank] is set, and wr_bank toggles.
- Frame check: on each accept, if in_last != (wcnt == N-1), frame_err is set and stays set until reset. Counting is unaffected; wcnt alone defines frame boundaries.
- Read side:
  - out_valid = full[rd_bank].
  - out_r/out_i = bank[rd_bank][rcnt] when out_valid is high, forced to 0 otherwise.
  - out_idx = rcnt; out_last = out_valid && rcnt == N-1.
- Read transfer: a transfer occurs on out_valid && out_ready, and rcnt increments.
  - On the transfer with rcnt == N-1: rcnt wraps to 0, full[rd_bank] is cleared, and rd_bank toggles.
- Latency: out_valid rises in the cycle after the N-th sample of a frame is accepted. Natural index 0 is presented in that cycle.
- Throughput: with out_ready held at 1, the block sustains one sample per cycle indefinitely with no bubbles.
- Simultaneous events:
  - A write completing one bank and a read completing the other bank in the same cycle are both applied.
  - When the write clears a full condition in the same cycle as the read frees a bank, in_ready follows the registered full flags. in_ready therefore rises one cycle after the draining bank's last transfer; it is not combinationally dependent on out_ready.
- Backpressure boundary: both banks full -> in_ready = 0. Inputs presented while in_ready = 0 are not accepted and have no effect. Output data stays stable while out_valid && !out_ready.
- Ordering: frames leave in the same order they entered. The bypass mode is applied per frame from the bank's latched bit.

Test Plan:
- Basic reorder (LOG2N=5, bypass=0, out_ready=1): send 32 samples with in_r = k, in_i = -k for k = 0..31 and in_last at k=31.
  - out_valid rises 1 cycle after the last accept.
  - Output sequence in_r: idx0 = 0, idx1 = 16, idx2 = 8, idx3 = 24, ..., idx31 = 31.
  - in_i is the negated value at each index; out_last is high only at idx31; frame_err stays 0.
- Bypass frame: same stimulus with bypass=1 at k=0, toggled to 0 at k=10 -> out_r = 0, 1, 2, ..., 31 in order, because mid-frame bypass changes are ignored.
- Backpressure: hold out_ready=0 and stream 70 samples.
  - 64 samples are accepted and in_ready falls after the 64th accept.
  - out_r holds 0 at idx0.
  - Release out_ready: frame 1 drains in bit-reversed-corrected order, in_ready rises the cycle after frame 1's idx31 transfer, and frame 2 follows.
- Continuous streaming: 4 back-to-back frames with out_ready=1 -> 128 contiguous out_valid cycles after the first frame's latency, in_ready constantly 1, and all values correct.
- Frame error: assert in_last at k=20 of a frame -> frame_err = 1 from the following cycle. The frame still completes after 32 accepts, and frame_err stays set across subsequent frames until rst=0.
- Mid-operation reset: drive rst=0 for 1 cycle after 40 accepts.
  - Next cycle: out_valid = 0, in_ready = 1, out_r = 0, frame_err = 0.
  - A fresh 32-sample frame then reorders correctly.
